// File: rtl/lcd_pkg.sv
// Shared LCD definitions: FSM states, command width, HD44780 codes,
// default post-command delays and the long-delay command classifier.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DELAY = 2'd2
  } lcd_state_t;

  localparam int unsigned CMD_W = 9;

  localparam logic [7:0] CODE_CLEAR = 8'h01;
  localparam logic [7:0] CODE_HOME  = 8'h02;

  localparam int unsigned DEF_DLY_W     = 18;
  localparam logic [17:0] DEF_SHORT_DLY = 18'd2150;
  localparam logic [17:0] DEF_LONG_DLY  = 18'd82000;

  // Clear Display and Return Home (0x01..0x03, bit 0 of Home is don't-care)
  // need the long execution time; everything else, including 0x00, is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CODE_CLEAR) || (data == CODE_HOME) ||
                   (data == (CODE_CLEAR | CODE_HOME)));
  endfunction

endpackage

// File: rtl/lcd_dly_timer.sv
// Loadable down-counter with zero flag; holds at zero once expired.
module lcd_dly_timer #(
  parameter int unsigned DLY_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] value,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  // Load takes precedence; otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Two-port command arbiter in front of the LCD raw controller.
// Port 0 = CPU instruction port, port 1 = character-RAM refresh scanner.
// Define LCD_ARB_RR_EN for round-robin tie-breaking; default is fixed
// priority with port 0 winning ties.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned      DLY_W     = DEF_DLY_W,
  parameter logic [DLY_W-1:0] SHORT_DLY = DEF_SHORT_DLY,
  parameter logic [DLY_W-1:0] LONG_DLY  = DEF_LONG_DLY
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [CMD_W-1:0] cmd0,
  output logic             ack0,
  input  logic             req1,
  input  logic [CMD_W-1:0] cmd1,
  output logic             ack1,
  output logic [7:0]       lcd_data,
  output logic             lcd_rs,
  output logic             lcd_start,
  input  logic             lcd_done,
  output logic             busy,
  output logic             gnt_id
);

  lcd_state_t       state, state_n;
  logic             start_n, rs_n, gnt_n, ack0_n, ack1_n;
  logic [7:0]       data_n;
  logic             win;
  logic [CMD_W-1:0] win_cmd;
  logic             dly_load, dly_zero;
  logic [DLY_W-1:0] dly_value;

`ifdef LCD_ARB_RR_EN
  logic prio;

  // Tie-break pointer: names the port to favour next; flips away from the
  // port that was just acknowledged.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if ((state == ST_BUSY) && lcd_done) begin
      prio <= ~gnt_id;
    end
  end

  // Lone requester wins; on a tie the pointer decides.
  always_comb begin
    win = (req0 && req1) ? prio : req1;
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    win = req1 && !req0;
  end
`endif

  assign win_cmd = win ? cmd1 : cmd0;

  lcd_dly_timer #(.DLY_W(DLY_W)) u_dly_timer (
    .clk   (sys_clk),
    .rst   (rst),
    .load  (dly_load),
    .value (dly_value),
    .zero  (dly_zero)
  );

  // State and registered outputs; reset drops any in-flight command.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lcd_start <= 1'b0;
      lcd_data  <= '0;
      lcd_rs    <= 1'b0;
      gnt_id    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state     <= state_n;
      lcd_start <= start_n;
      lcd_data  <= data_n;
      lcd_rs    <= rs_n;
      gnt_id    <= gnt_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
    end
  end

  // Next-state and next-output decode; the delay is loaded on the same edge
  // that enters DELAY, so the ack cycle sees the full count.
  always_comb begin
    state_n   = state;
    start_n   = lcd_start;
    data_n    = lcd_data;
    rs_n      = lcd_rs;
    gnt_n     = gnt_id;
    ack0_n    = 1'b0;
    ack1_n    = 1'b0;
    dly_load  = 1'b0;
    dly_value = is_long_cmd(lcd_rs, lcd_data) ? LONG_DLY : SHORT_DLY;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_n = ST_BUSY;
          start_n = 1'b1;
          rs_n    = win_cmd[8];
          data_n  = win_cmd[7:0];
          gnt_n   = win;
        end
      end
      ST_BUSY: begin
        if (lcd_done) begin
          state_n  = ST_DELAY;
          start_n  = 1'b0;
          ack0_n   = ~gnt_id;
          ack1_n   = gnt_id;
          dly_load = 1'b1;
        end
      end
      ST_DELAY: begin
        if (dly_zero) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        start_n = 1'b0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
